receiver_block_scheduler: RTL and testbench

Round-robin scheduler that drains decoded BMC blocks from several lighthouse receiver channels into a single output stream. It sits between N receiver-manager channels, each exposing a decoded-block RAM read port (block index in, 41-bit block + ready out, available count out), and the downstream packetizer/host link. The scheduler reads every newly available block exactly once, tags it with its channel id and presents it on a valid/ready handshake.

---
 rtl/receiver_block_scheduler_pkg.sv | 16 +
 rtl/receiver_block_scheduler_if.sv | 14 +
 rtl/receiver_block_scheduler_rr_channel_pointer.sv | 22 ++
 rtl/receiver_block_scheduler.sv | 158 +++++++++++++++
 tb/tb_receiver_block_scheduler.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/receiver_block_scheduler_pkg.sv
// Shared widths, defaults and FSM state type for the receiver block scheduler.
package receiver_block_scheduler_pkg;
  localparam int unsigned DATA_W          = 17;
  localparam int unsigned TS_W            = 24;
  localparam int unsigned BLOCK_W         = DATA_W + TS_W;
  localparam int unsigned PTR_W           = 8;
  localparam int unsigned SETTLE_CYC_DEF  = 2;
  localparam int unsigned TIMEOUT_CYC_DEF = 64;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    SETTLE   = 2'd1,
    WAIT_RDY = 2'd2,
    PRESENT  = 2'd3
  } sched_state_t;
endpackage

// File: rtl/receiver_block_scheduler_if.sv
// Output block stream towards the packetizer: tagged block on a valid/ready handshake.
interface receiver_block_scheduler_if #(
  parameter int unsigned ID_W = 2
);
  import receiver_block_scheduler_pkg::*;

  logic [BLOCK_W-1:0] out_block;
  logic [ID_W-1:0]    out_id;
  logic               out_valid;
  logic               out_ready;

  modport master (output out_block, output out_id, output out_valid, input out_ready);
  modport slave  (input out_block, input out_id, input out_valid, output out_ready);
endinterface

// File: rtl/receiver_block_scheduler_rr_channel_pointer.sv
// Round-robin current-channel counter; advances one channel per i_advance with modulo wrap.
module rr_channel_pointer #(
  parameter int unsigned NB_RECEIVERS = 4,
  parameter int unsigned ID_W         = $clog2(NB_RECEIVERS)
) (
  input  logic            clk_96MHz,
  input  logic            reset_n,
  input  logic            i_advance,
  output logic [ID_W-1:0] o_cur
);
  logic [ID_W-1:0] r_cur;

  always_ff @(posedge clk_96MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_cur <= '0;
    end else if (i_advance) begin
      r_cur <= (r_cur == ID_W'(NB_RECEIVERS - 1)) ? '0 : r_cur + 1'b1;
    end
  end

  assign o_cur = r_cur;
endmodule

// File: rtl/receiver_block_scheduler.sv
// Drains newly available decoded blocks from N receiver channels, one per channel visit, into one stream.
module receiver_block_scheduler
  import receiver_block_scheduler_pkg::*;
#(
  parameter int unsigned NB_RECEIVERS = 4,
  parameter int unsigned SETTLE_CYC   = SETTLE_CYC_DEF,
  parameter int unsigned TIMEOUT_CYC  = TIMEOUT_CYC_DEF,
  parameter int unsigned ID_W         = $clog2(NB_RECEIVERS)
) (
  input  logic                              clk_96MHz,
  input  logic                              reset_n,
  output logic [PTR_W*NB_RECEIVERS-1:0]     block_wanted_number,
  input  logic [BLOCK_W*NB_RECEIVERS-1:0]   block_wanted,
  input  logic [NB_RECEIVERS-1:0]           data_ready,
  input  logic [PTR_W*NB_RECEIVERS-1:0]     avl_blocks_nb,
  receiver_block_scheduler_if.master        out_if,
  output logic [7:0]                        timeout_cnt
);
  localparam int unsigned CNT_MAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  sched_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [ID_W-1:0]    w_cur;
  logic [PTR_W-1:0]   r_rd_ptr  [NB_RECEIVERS];
  logic [PTR_W-1:0]   w_ptr_eff [NB_RECEIVERS];
  logic [PTR_W-1:0]   w_ptr_cur, w_avl_cur;
  logic               w_rdy_cur;
  logic [BLOCK_W-1:0] w_blk_cur;
  logic               w_advance, w_req, w_latch, w_accept, w_timeout;
  logic [PTR_W*NB_RECEIVERS-1:0] r_bwn;
  logic [BLOCK_W-1:0] r_out_block;
  logic [ID_W-1:0]    r_out_id;
  logic               r_out_valid;
  logic [7:0]         r_timeout_cnt;

  rr_channel_pointer #(
    .NB_RECEIVERS (NB_RECEIVERS),
    .ID_W         (ID_W)
  ) u_rr_channel_pointer (
    .clk_96MHz (clk_96MHz),
    .reset_n   (reset_n),
    .i_advance (w_advance),
    .o_cur     (w_cur)
  );

  // A shrunken avl count means the channel RAM was refilled: treat the pointer as 0 right away.
  always_comb begin
    w_ptr_cur = '0;
    w_avl_cur = '0;
    w_rdy_cur = 1'b0;
    w_blk_cur = '0;
    for (int unsigned i = 0; i < NB_RECEIVERS; i++) begin
      w_ptr_eff[i] = (avl_blocks_nb[PTR_W*i +: PTR_W] < r_rd_ptr[i]) ? '0 : r_rd_ptr[i];
      if (w_cur == ID_W'(i)) begin
        w_ptr_cur = w_ptr_eff[i];
        w_avl_cur = avl_blocks_nb[PTR_W*i +: PTR_W];
        w_rdy_cur = data_ready[i];
        w_blk_cur = block_wanted[BLOCK_W*i +: BLOCK_W];
      end
    end
  end

  always_ff @(posedge clk_96MHz or negedge reset_n) begin
    if (!reset_n) r_state <= SCAN;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_advance   = 1'b0;
    w_req       = 1'b0;
    w_latch     = 1'b0;
    w_accept    = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      SCAN: begin
        if (w_ptr_cur != w_avl_cur) begin
          w_req       = 1'b1;
          w_state_nxt = SETTLE;
        end else begin
          w_advance = 1'b1;
        end
      end
      SETTLE: begin
        if (r_cnt == CNT_W'(SETTLE_CYC - 1)) w_state_nxt = WAIT_RDY;
      end
      WAIT_RDY: begin
        if (w_rdy_cur) begin
          w_latch     = 1'b1;
          w_state_nxt = PRESENT;
        end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          w_timeout   = 1'b1;
          w_advance   = 1'b1;
          w_state_nxt = SCAN;
        end
      end
      PRESENT: begin
        if (out_if.out_ready) begin
          w_accept    = 1'b1;
          w_advance   = 1'b1;
          w_state_nxt = SCAN;
        end
      end
      default: w_state_nxt = SCAN;
    endcase
  end

  always_ff @(posedge clk_96MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_cnt <= '0;
    end else if (r_state == SETTLE || r_state == WAIT_RDY) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_96MHz or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NB_RECEIVERS; i++) r_rd_ptr[i] <= '0;
      r_bwn <= '0;
    end else begin
      for (int unsigned i = 0; i < NB_RECEIVERS; i++) begin
        if (avl_blocks_nb[PTR_W*i +: PTR_W] < r_rd_ptr[i]) begin
          r_rd_ptr[i] <= '0;
        end else if (w_accept && w_cur == ID_W'(i)) begin
          r_rd_ptr[i] <= r_rd_ptr[i] + 1'b1;
        end
        if (w_req && w_cur == ID_W'(i)) r_bwn[PTR_W*i +: PTR_W] <= w_ptr_cur;
      end
    end
  end

  always_ff @(posedge clk_96MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_out_block   <= '0;
      r_out_id      <= '0;
      r_out_valid   <= 1'b0;
      r_timeout_cnt <= '0;
    end else begin
      if (w_latch) begin
        r_out_block <= w_blk_cur;
        r_out_id    <= w_cur;
        r_out_valid <= 1'b1;
      end else if (w_accept) begin
        r_out_valid <= 1'b0;
      end
      if (w_timeout && r_timeout_cnt != 8'hFF) r_timeout_cnt <= r_timeout_cnt + 1'b1;
    end
  end

  assign block_wanted_number = r_bwn;
  assign out_if.out_block    = r_out_block;
  assign out_if.out_id       = r_out_id;
  assign out_if.out_valid    = r_out_valid;
  assign timeout_cnt         = r_timeout_cnt;
endmodule

// File: tb/tb_receiver_block_scheduler.sv
// Scoreboard bench for receiver_block_scheduler: channel RAM model, expected-output queue, timing checks.
module tb_receiver_block_scheduler;
  import receiver_block_scheduler_pkg::*;

  localparam int unsigned NB   = 4;
  localparam int unsigned ID_W = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [PTR_W*NB-1:0]   bwn;
  logic [PTR_W*NB-1:0]   avl;
  logic [BLOCK_W*NB-1:0] bw;
  logic [NB-1:0]         rdy_en;
  logic [7:0]            tcnt;

  receiver_block_scheduler_if #(.ID_W(ID_W)) sif ();

  receiver_block_scheduler #(
    .NB_RECEIVERS (NB),
    .SETTLE_CYC   (2),
    .TIMEOUT_CYC  (64),
    .ID_W         (ID_W)
  ) dut (
    .clk_96MHz           (clk),
    .reset_n             (rst_n),
    .block_wanted_number (bwn),
    .block_wanted        (bw),
    .data_ready          (rdy_en),
    .avl_blocks_nb       (avl),
    .out_if              (sif),
    .timeout_cnt         (tcnt)
  );

  function automatic logic [BLOCK_W-1:0] blk_of(int unsigned ch, logic [7:0] idx);
    logic [DATA_W-1:0] d;
    logic [TS_W-1:0]   ts;
    d  = DATA_W'(ch * 256 + idx) ^ 17'h15A5A;
    ts = TS_W'(ch * 65536 + idx * 3 + 256);
    return {d, ts};
  endfunction

  for (genvar g = 0; g < NB; g++) begin : g_ram
    assign bw[g*BLOCK_W +: BLOCK_W] = blk_of(g, bwn[g*PTR_W +: PTR_W]);
  end

  typedef struct {
    int unsigned        id;
    logic [BLOCK_W-1:0] blk;
  } exp_t;
  exp_t q[$];

  int     n_cmp = 0;
  int     n_err = 0;
  longint cyc   = 0;
  always @(posedge clk) cyc++;

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Each accepted beat is matched against the oldest expected block.
  always @(negedge clk) begin
    if (rst_n && sif.out_valid && sif.out_ready) begin
      if (q.size() == 0) begin
        check_eq("spurious_out", 64'(q.size()), 64'd1);
      end else begin
        exp_t e;
        e = q.pop_front();
        check_eq("out_id", 64'(sif.out_id), 64'(e.id));
        check_eq("out_block", 64'(sif.out_block), 64'(e.blk));
      end
    end
  end

  task automatic push(int unsigned ch, int unsigned idx);
    exp_t e;
    e.id  = ch;
    e.blk = blk_of(ch, 8'(idx));
    q.push_back(e);
  endtask

  task automatic set_avl(int unsigned ch, int unsigned v);
    avl[ch*PTR_W +: PTR_W] = 8'(v);
  endtask

  task automatic drain(string tag);
    for (int k = 0; k < 600 && q.size() != 0; k++) @(posedge clk);
    #1;
    check_eq(tag, 64'(q.size()), 64'd0);
    q.delete();
    repeat (12) @(posedge clk);
    #1;
    check_eq({tag, "_idle"}, 64'(sif.out_valid), 64'd0);
  endtask

  task automatic wait_valid(string tag);
    for (int k = 0; k < 200 && !sif.out_valid; k++) @(posedge clk);
    #1;
    check_eq(tag, 64'(sif.out_valid), 64'd1);
  endtask

  task automatic wait_tcnt(string tag, logic [7:0] v, int unsigned bound, output longint at);
    for (int unsigned k = 0; k < bound && tcnt != v; k++) begin
      @(posedge clk);
      #1;
    end
    at = cyc;
    check_eq(tag, 64'(tcnt), 64'(v));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    avl = '0;
    rdy_en = '1;
    sif.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    longint c1, c2;
    avl = '0;
    rdy_en = '1;
    sif.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", 64'(sif.out_valid), 64'd0);
    check_eq("rst_block", 64'(sif.out_block), 64'd0);
    check_eq("rst_id", 64'(sif.out_id), 64'd0);
    check_eq("rst_tcnt", 64'(tcnt), 64'd0);
    check_eq("rst_bwn", 64'(bwn), 64'd0);

    // minimum latency: 4 rising edges from pending to out_valid
    @(negedge clk);
    rst_n = 1'b1;
    set_avl(0, 1);
    push(0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("lat_early", 64'(sif.out_valid), 64'd0);
    @(posedge clk);
    #1;
    check_eq("lat_valid", 64'(sif.out_valid), 64'd1);
    sif.out_ready = 1'b1;
    drain("lat_drain");

    set_avl(1, 3);
    for (int unsigned i = 0; i < 3; i++) push(1, i);
    drain("ch1_seq");
    check_eq("ch1_bwn", 64'(bwn[15:8]), 64'd2);

    apply_reset();
    sif.out_ready = 1'b1;
    set_avl(0, 2);
    set_avl(2, 2);
    push(0, 0); push(2, 0); push(0, 1); push(2, 1);
    drain("rr_order");

    sif.out_ready = 1'b0;
    set_avl(3, 1);
    push(3, 0);
    wait_valid("bp_valid");
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      check_eq("bp_hold_valid", 64'(sif.out_valid), 64'd1);
      check_eq("bp_hold_id", 64'(sif.out_id), 64'd3);
      check_eq("bp_hold_block", 64'(sif.out_block), 64'(blk_of(3, 8'd0)));
    end
    sif.out_ready = 1'b1;
    drain("bp_release");

    rdy_en[3] = 1'b0;
    set_avl(3, 2);
    wait_tcnt("tmo_first", 8'd1, 300, c1);
    check_eq("tmo_bwn", 64'(bwn[31:24]), 64'd1);
    wait_tcnt("tmo_second", 8'd2, 300, c2);
    check_eq("tmo_period", 64'(c2 - c1), 64'd70);
    wait_tcnt("tmo_reach_sat", 8'hFF, 20000, c2);
    repeat (150) @(posedge clk);
    #1;
    check_eq("tmo_saturate", 64'(tcnt), 64'hFF);
    rdy_en[3] = 1'b1;
    push(3, 1);
    drain("tmo_retry");

    set_avl(0, 5);
    push(0, 2); push(0, 3); push(0, 4);
    drain("clr_fill");
    set_avl(0, 1);
    push(0, 0);
    drain("clr_reread");
    check_eq("clr_bwn", 64'(bwn[7:0]), 64'd0);

    sif.out_ready = 1'b0;
    avl = '0;
    repeat (8) @(posedge clk);
    #1;
    set_avl(1, 1);
    push(1, 0);
    wait_valid("rst_mid_valid");
    check_eq("rst_mid_block", 64'(sif.out_block), 64'(blk_of(1, 8'd0)));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_valid", 64'(sif.out_valid), 64'd0);
    check_eq("rst_async_block", 64'(sif.out_block), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sif.out_ready = 1'b1;
    drain("rst_redeliver");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
